// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader
//
// Receives a program image as a byte stream and writes it into program memory,
// holding the CPU in reset until the image is in place. It then releases the
// CPU once the image is loaded and, if enabled, its checksum has been verified.
//
// Stream format: <len> <data0> ... <dataN-1> [<csum>]
//   len  : number of data bytes; 0 means 256
//   csum : 8-bit modulo-256 sum of the data bytes (present only if CSUM_EN=1)
//
// Parameters
//   CSUM_EN   1: a checksum byte follows the data and is checked
//             0: no checksum phase; the CPU is released after the last data byte
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   start      in   synchronous request to (re)start a load
//   rx_valid   in   upstream byte available
//   rx_byte    in   upstream byte [7:0]
//   rx_ready   out  loader accepts a byte this cycle (combinational)
//   mem_we     out  program-memory write strobe (one cycle per data byte)
//   mem_addr   out  program-memory write address [7:0]
//   mem_data   out  program-memory write data [7:0]
//   cpu_reset  out  holds the CPU in reset while high
//   done       out  load completed and verified; CPU running
//   err        out  checksum mismatch; CPU held in reset
// ---------------------------------------------------------------------------
module prog_loader #(
    parameter int CSUM_EN = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    output logic       rx_ready,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_data,
    output logic       cpu_reset,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        LEN  = 3'd0,
        DATA = 3'd1,
        CSUM = 3'd2,
        RUN  = 3'd3,
        ERR  = 3'd4
    } loaderState;

    loaderState stateReg;
    loaderState stateNext;

    logic [8:0] countReg;     // 9 bits so that a length byte of 0 can mean 256
    logic [7:0] addrReg;
    logic [7:0] sumReg;

    logic       xfer;
    logic       cpuResetNext;
    logic       doneNext;
    logic       errNext;

    assign xfer = rx_valid & rx_ready;

    // -----------------------------------------------------------------------
    // State register. The status outputs are registered from the next-state
    // decode so that they change on the same edge as the state itself.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateReg  <= LEN;
            cpu_reset <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            stateReg  <= stateNext;
            cpu_reset <= cpuResetNext;
            done      <= doneNext;
            err       <= errNext;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic. start overrides any transfer in the same cycle.
    // -----------------------------------------------------------------------
    always_comb begin
        stateNext = stateReg;
        if (start) begin
            stateNext = LEN;
        end else if (xfer) begin
            case (stateReg)
                LEN:  stateNext = DATA;
                DATA: begin
                    // count is never 0 in DATA (0 is loaded as 256)
                    if (countReg == 9'd1) begin
                        stateNext = (CSUM_EN != 0) ? CSUM : RUN;
                    end
                end
                CSUM: stateNext = (rx_byte == sumReg) ? RUN : ERR;
                default: stateNext = stateReg;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Output decode
    // -----------------------------------------------------------------------
    always_comb begin
        rx_ready     = (stateReg == LEN) || (stateReg == DATA) || (stateReg == CSUM);
        cpuResetNext = (stateNext != RUN);
        doneNext     = (stateNext == RUN);
        errNext      = (stateNext == ERR);
    end

    // -----------------------------------------------------------------------
    // Datapath: counters, running checksum and the memory write port.
    // mem_addr/mem_data only change together with a write strobe, so they
    // hold their last values between writes.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_we   <= 1'b0;
            mem_addr <= 8'd0;
            mem_data <= 8'd0;
            countReg <= 9'd0;
            addrReg  <= 8'd0;
            sumReg   <= 8'd0;
        end else begin
            mem_we <= 1'b0;
            if (start) begin
                // A byte arriving with start is swallowed without effect.
                countReg <= 9'd0;
                addrReg  <= 8'd0;
                sumReg   <= 8'd0;
            end else if (xfer) begin
                case (stateReg)
                    LEN: begin
                        countReg <= (rx_byte == 8'd0) ? 9'd256 : {1'b0, rx_byte};
                        addrReg  <= 8'd0;
                        sumReg   <= 8'd0;
                    end
                    DATA: begin
                        mem_we   <= 1'b1;
                        mem_addr <= addrReg;
                        mem_data <= rx_byte;
                        addrReg  <= addrReg + 8'd1;
                        sumReg   <= sumReg + rx_byte;
                        countReg <= countReg - 9'd1;
                    end
                    default: begin
                        countReg <= countReg;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_prog_loader
//
// Directed test of prog_loader. Two instances share the upstream stimulus:
// dut (checksum enabled) and dut0 (checksum disabled, kept in reset until its
// own test). Memory writes are captured on the falling edge into queues along
// with the cycle number, and compared against hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       reset0;
    logic       start;
    logic       rx_valid;
    logic [7:0] rx_byte;

    logic       rxReady, memWe, cpuReset, doneOut, errOut;
    logic [7:0] memAddr, memData;
    logic       rxReady0, memWe0, cpuReset0, doneOut0, errOut0;
    logic [7:0] memAddr0, memData0;

    prog_loader #(.CSUM_EN(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .rx_valid  (rx_valid),
        .rx_byte   (rx_byte),
        .rx_ready  (rxReady),
        .mem_we    (memWe),
        .mem_addr  (memAddr),
        .mem_data  (memData),
        .cpu_reset (cpuReset),
        .done      (doneOut),
        .err       (errOut)
    );

    prog_loader #(.CSUM_EN(0)) dut0 (
        .clk       (clk),
        .reset     (reset0),
        .start     (start),
        .rx_valid  (rx_valid),
        .rx_byte   (rx_byte),
        .rx_ready  (rxReady0),
        .mem_we    (memWe0),
        .mem_addr  (memAddr0),
        .mem_data  (memData0),
        .cpu_reset (cpuReset0),
        .done      (doneOut0),
        .err       (errOut0)
    );

    always #5 clk = ~clk;

    int cycleCnt = 0;
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    logic [15:0] wrQ[$];
    int          wrCyc[$];
    logic [15:0] wrQ0[$];

    always @(negedge clk) begin
        if (memWe) begin
            wrQ.push_back({memAddr, memData});
            wrCyc.push_back(cycleCnt);
        end
        if (memWe0) begin
            wrQ0.push_back({memAddr0, memData0});
        end
    end

    int checks = 0;
    int errors = 0;
    int lastAcc = 0;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    // Called at posedge+1; returns at the following posedge+1 with rx_valid still high.
    task automatic sendByte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        lastAcc  = cycleCnt;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        reset    = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        wrQ.delete();
        wrCyc.delete();
    endtask

    logic [7:0]  stream34 [5];
    int          accCyc [3];
    logic [15:0] tmp;
    int          bad;

    initial begin
        reset    = 1'b0;
        reset0   = 1'b0;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        #1;
        reset  = 1'b1;
        reset0 = 1'b1;
        #2;
        // Reset state, before any clock edge
        checkVal("rst_cpu_reset", 32'(cpuReset), 32'h1);
        checkVal("rst_done",      32'(doneOut),  32'h0);
        checkVal("rst_err",       32'(errOut),   32'h0);
        checkVal("rst_mem_we",    32'(memWe),    32'h0);
        checkVal("rst_mem_addr",  32'(memAddr),  32'h0);
        checkVal("rst_mem_data",  32'(memData),  32'h0);
        checkVal("rst_rx_ready",  32'(rxReady),  32'h1);
        @(posedge clk);
        #1;

        // ---- Basic load with valid checksum ----
        doReset();
        sendByte(8'h03);
        sendByte(8'h11);
        sendByte(8'h22);
        sendByte(8'h33);
        sendByte(8'h66);
        rx_valid = 1'b0;
        checkVal("t30_done",      32'(doneOut),  32'h1);
        checkVal("t30_cpu_reset", 32'(cpuReset), 32'h0);
        checkVal("t30_rx_ready",  32'(rxReady),  32'h0);
        checkVal("t30_err",       32'(errOut),   32'h0);
        @(posedge clk);
        #1;
        checkVal("t30_nwr", 32'(wrQ.size()), 32'd3);
        checkVal("t30_w0",  32'(wrQ[0]), 32'h0011);
        checkVal("t30_w1",  32'(wrQ[1]), 32'h0122);
        checkVal("t30_w2",  32'(wrQ[2]), 32'h0233);
        checkVal("t30_consec1", 32'(wrCyc[1] - wrCyc[0]), 32'd1);
        checkVal("t30_consec2", 32'(wrCyc[2] - wrCyc[1]), 32'd1);
        checkVal("t30_hold_data", 32'(memData), 32'h33);

        // ---- Bad checksum ----
        doReset();
        sendByte(8'h02);
        sendByte(8'h10);
        sendByte(8'h20);
        sendByte(8'h00);
        rx_valid = 1'b0;
        checkVal("t31_err",       32'(errOut),   32'h1);
        checkVal("t31_cpu_reset", 32'(cpuReset), 32'h1);
        checkVal("t31_done",      32'(doneOut),  32'h0);
        checkVal("t31_rx_ready",  32'(rxReady),  32'h0);
        sendByte(8'h55);
        sendByte(8'h56);
        rx_valid = 1'b0;
        @(posedge clk);
        #1;
        checkVal("t31_nwr", 32'(wrQ.size()), 32'd2);
        checkVal("t31_w0",  32'(wrQ[0]), 32'h0010);
        checkVal("t31_w1",  32'(wrQ[1]), 32'h0120);
        checkVal("t31_err_hold", 32'(errOut), 32'h1);

        // ---- 256-byte load (length 00) ----
        doReset();
        sendByte(8'h00);
        for (int i = 0; i < 256; i++) begin
            sendByte(8'(i));
        end
        sendByte(8'h80);
        rx_valid = 1'b0;
        checkVal("t32_done", 32'(doneOut), 32'h1);
        @(posedge clk);
        #1;
        checkVal("t32_nwr", 32'(wrQ.size()), 32'd256);
        bad = 0;
        for (int i = 0; i < wrQ.size(); i++) begin
            if (wrQ[i] !== {8'(i), 8'(i)}) bad++;
        end
        checkVal("t32_seq_bad", 32'(bad), 32'd0);
        tmp = wrQ[wrQ.size() - 1];
        checkVal("t32_last_addr", 32'(tmp[15:8]), 32'hFF);

        // ---- start aborts a load; the concurrent byte is discarded ----
        doReset();
        sendByte(8'h04);
        sendByte(8'hAA);
        sendByte(8'hBB);
        start   = 1'b1;
        rx_byte = 8'hCC;
        @(posedge clk);
        #1;
        start    = 1'b0;
        rx_valid = 1'b0;
        checkVal("t33_rx_ready", 32'(rxReady),  32'h1);
        checkVal("t33_cpu_reset", 32'(cpuReset), 32'h1);
        checkVal("t33_done",     32'(doneOut),  32'h0);
        // start while already in LEN
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        checkVal("t33_nwr_abort", 32'(wrQ.size()), 32'd2);
        checkVal("t33_hold_addr", 32'(memAddr), 32'h01);
        checkVal("t33_hold_data", 32'(memData), 32'hBB);
        sendByte(8'h01);
        sendByte(8'h55);
        sendByte(8'h55);
        rx_valid = 1'b0;
        checkVal("t33_done2", 32'(doneOut), 32'h1);
        @(posedge clk);
        #1;
        checkVal("t33_nwr", 32'(wrQ.size()), 32'd3);
        checkVal("t33_w2",  32'(wrQ[2]), 32'h0055);

        // ---- rx_valid toggling every other cycle ----
        doReset();
        stream34[0] = 8'h03;
        stream34[1] = 8'h01;
        stream34[2] = 8'h02;
        stream34[3] = 8'h03;
        stream34[4] = 8'h06;
        for (int k = 0; k < 5; k++) begin
            sendByte(stream34[k]);
            if (k >= 1 && k <= 3) accCyc[k - 1] = lastAcc;
            rx_valid = 1'b0;
            rx_byte  = 8'hEE;
            @(posedge clk);
            #1;
        end
        checkVal("t34_done", 32'(doneOut), 32'h1);
        checkVal("t34_nwr",  32'(wrQ.size()), 32'd3);
        for (int k = 0; k < 3; k++) begin
            checkVal($sformatf("t34_w%0d", k), 32'(wrQ[k]), 32'({8'(k), 8'(k + 1)}));
            checkVal($sformatf("t34_lat%0d", k), 32'(wrCyc[k] - accCyc[k]), 32'd1);
        end

        // ---- reset mid-load abandons the load ----
        doReset();
        sendByte(8'h03);
        sendByte(8'h11);
        rx_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checkVal("t29_async_we",   32'(memWe),   32'h0);
        checkVal("t29_async_addr", 32'(memAddr), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        wrQ.delete();
        wrCyc.delete();
        sendByte(8'h01);
        sendByte(8'h44);
        sendByte(8'h44);
        rx_valid = 1'b0;
        checkVal("t29_done", 32'(doneOut), 32'h1);
        @(posedge clk);
        #1;
        checkVal("t29_nwr", 32'(wrQ.size()), 32'd1);
        checkVal("t29_w0",  32'(wrQ[0]), 32'h0044);

        // ---- CSUM_EN=0 instance ----
        reset0 = 1'b0;
        sendByte(8'h01);
        sendByte(8'h7F);
        rx_byte = 8'h99;   // would-be checksum, must not be taken
        checkVal("t35_done",      32'(doneOut0),  32'h1);
        checkVal("t35_cpu_reset", 32'(cpuReset0), 32'h0);
        checkVal("t35_rx_ready",  32'(rxReady0),  32'h0);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        checkVal("t35_done_hold", 32'(doneOut0), 32'h1);
        checkVal("t35_nwr", 32'(wrQ0.size()), 32'd1);
        checkVal("t35_w0",  32'(wrQ0[0]), 32'h007F);
        #2;
        reset0 = 1'b1;
        #1;
        checkVal("t35_async_cpu_reset", 32'(cpuReset0), 32'h1);
        checkVal("t35_async_done",      32'(doneOut0),  32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
